// File: rtl/wb_master_arbiter_pkg.sv
// Shared Wishbone types for the master arbiter: pipelined bus request/response
// records, bus widths and the response an unselected requester sees.
package wb_master_arbiter_pkg;

  localparam int c_wishbone_address_width = 32;
  localparam int c_wishbone_data_width    = 32;
  localparam int c_wishbone_sel_width     = c_wishbone_data_width / 8;

  typedef logic [c_wishbone_address_width-1:0] t_wishbone_address;
  typedef logic [c_wishbone_data_width-1:0]    t_wishbone_data;
  typedef logic [c_wishbone_sel_width-1:0]     t_wishbone_byte_select;

  typedef struct packed {
    logic                  cyc;
    logic                  stb;
    t_wishbone_address     adr;
    t_wishbone_byte_select sel;
    logic                  we;
    t_wishbone_data        dat;
  } t_wishbone_master_out;

  typedef struct packed {
    logic           ack;
    logic           err;
    logic           rty;
    logic           stall;
    t_wishbone_data dat;
  } t_wishbone_master_in;

  // A requester without the bus is held off with stall and never sees a response.
  localparam t_wishbone_master_in c_wb_idle_response = '{
    ack: 1'b0, err: 1'b0, rty: 1'b0, stall: 1'b1, dat: '0
  };

  function automatic logic wb_is_response(input t_wishbone_master_in r);
    return r.ack | r.err | r.rty;
  endfunction

endpackage

// File: rtl/wb_rr_select.sv
// Round-robin priority selector: the first active request after the last owner
// (wrapping) wins; returns it one-hot and as an index.
module wb_rr_select #(
  parameter int g_n = 2
) (
  input  logic [g_n-1:0]         req,
  input  logic [$clog2(g_n)-1:0] last_owner,
  output logic [g_n-1:0]         grant,
  output logic [$clog2(g_n)-1:0] grant_idx,
  output logic                   valid
);

  localparam int c_idx_w = $clog2(g_n);

  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    for (int i = 1; i <= g_n; i++) begin
      idx = (int'(last_owner) + i) % g_n;
      if (!valid && req[idx]) begin
        valid      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx[c_idx_w-1:0];
      end
    end
  end

endmodule

// File: rtl/wb_master_arbiter.sv
// Multi-master Wishbone arbiter: round-robin ownership of one pipelined bus,
// outstanding-transfer throttling and a watchdog that aborts a silent slave.
module wb_master_arbiter
  import wb_master_arbiter_pkg::*;
#(
  parameter int g_num_masters     = 2,
  parameter int g_max_outstanding = 16,
  parameter int g_timeout         = 1024
) (
  input  logic                                     clk_i,
  input  logic                                     rst_n_i,
  input  t_wishbone_master_out [g_num_masters-1:0] slave_i,
  output t_wishbone_master_in  [g_num_masters-1:0] slave_o,
  output t_wishbone_master_out                     master_o,
  input  t_wishbone_master_in                      master_i,
  output logic [g_num_masters-1:0]                 grant_o,
  output logic                                     timeout_o
);

  localparam int c_idx_w = $clog2(g_num_masters);
  localparam int c_cnt_w = $clog2(g_max_outstanding) + 1;
  localparam int c_wd_w  = $clog2(g_timeout + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(g_max_outstanding);
  localparam logic [c_wd_w-1:0]  c_wd_last = c_wd_w'(g_timeout - 1);

  typedef enum logic [1:0] {IDLE, BUSY, ABORT} t_state;

  t_state                   state;
  logic [c_idx_w-1:0]       owner;
  logic [c_idx_w-1:0]       last_owner;
  logic [c_cnt_w-1:0]       outstanding;
  logic [c_wd_w-1:0]        watchdog;
  logic [g_num_masters-1:0] req;
  logic [g_num_masters-1:0] next_grant;
  logic [c_idx_w-1:0]       next_idx;
  logic                     next_valid;
  logic                     owner_cyc;
  logic                     at_max;
  logic                     accept;
  logic                     response;

  always_comb begin
    for (int k = 0; k < g_num_masters; k++) req[k] = slave_i[k].cyc;
  end

  wb_rr_select #(.g_n(g_num_masters)) u_select (
    .req        (req),
    .last_owner (last_owner),
    .grant      (next_grant),
    .grant_idx  (next_idx),
    .valid      (next_valid)
  );

  assign owner_cyc = slave_i[owner].cyc;
  assign at_max    = (outstanding == c_cnt_max);
  assign response  = wb_is_response(master_i);
  assign accept    = master_o.stb & ~master_i.stall;

  // Owner is wired straight through; responses after the owner drops cyc are swallowed.
  always_comb begin
    master_o = '0;
    for (int k = 0; k < g_num_masters; k++) slave_o[k] = c_wb_idle_response;
    if (rst_n_i) begin
      case (state)
        BUSY: begin
          master_o             = slave_i[owner];
          master_o.stb         = slave_i[owner].stb & owner_cyc & ~at_max;
          slave_o[owner]       = master_i;
          slave_o[owner].ack   = master_i.ack & owner_cyc;
          slave_o[owner].err   = master_i.err & owner_cyc;
          slave_o[owner].rty   = master_i.rty & owner_cyc;
          slave_o[owner].stall = master_i.stall | at_max;
        end
        ABORT:   slave_o[owner].err = timeout_o;
        default: ;
      endcase
    end
  end

  // The watchdog reaches g_timeout on the edge closing the g_timeout-th silent
  // cycle; timeout_o and the owner's err both mark the first ABORT cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      grant_o     <= '0;
      owner       <= '0;
      last_owner  <= c_idx_w'(g_num_masters - 1);
      outstanding <= '0;
      watchdog    <= '0;
      timeout_o   <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      case (state)
        IDLE: begin
          if (next_valid) begin
            grant_o    <= next_grant;
            owner      <= next_idx;
            last_owner <= next_idx;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (!owner_cyc) begin
            state       <= IDLE;
            grant_o     <= '0;
            outstanding <= '0;
            watchdog    <= '0;
          end else begin
            if (accept && !response)
              outstanding <= outstanding + 1'b1;
            else if (!accept && response && outstanding != '0)
              outstanding <= outstanding - 1'b1;
            if (response || outstanding == '0) begin
              watchdog <= '0;
            end else if (watchdog == c_wd_last) begin
              state       <= ABORT;
              timeout_o   <= 1'b1;
              outstanding <= '0;
              watchdog    <= '0;
            end else begin
              watchdog <= watchdog + 1'b1;
            end
          end
        end
        ABORT: begin
          if (!owner_cyc) begin
            state   <= IDLE;
            grant_o <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for wb_master_arbiter: two masters, outstanding limit 2,
// watchdog 8; responses are tracked through a scoreboard queue.
module tb_wb_master_arbiter;
  import wb_master_arbiter_pkg::*;

  localparam int c_n = 2;

  logic                             clk_i = 1'b0;
  logic                             rst_n_i;
  t_wishbone_master_out [c_n-1:0]   slave_i;
  t_wishbone_master_in  [c_n-1:0]   slave_o;
  t_wishbone_master_out             master_o;
  t_wishbone_master_in              master_i;
  logic [c_n-1:0]                   grant_o;
  logic                             timeout_o;

  int          checks = 0;
  int          errors = 0;
  int          exp_idx_q[$];
  logic [31:0] exp_dat_q[$];
  logic [31:0] pend_q[$];

  wb_master_arbiter #(
    .g_num_masters     (c_n),
    .g_max_outstanding (2),
    .g_timeout         (8)
  ) dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .slave_i   (slave_i),
    .slave_o   (slave_o),
    .master_o  (master_o),
    .master_i  (master_i),
    .grant_o   (grant_o),
    .timeout_o (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] resp_data(input logic [31:0] adr);
    return adr ^ 32'hA5A5_0000;
  endfunction

  // Inputs change 2ns after the rising edge; responses last a single cycle.
  task automatic next_cycle();
    @(posedge clk_i);
    #2;
    master_i.ack = 1'b0;
    master_i.err = 1'b0;
    master_i.rty = 1'b0;
    master_i.dat = '0;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic apply_stimulus(input int k, input logic cyc, input logic stb,
                                input logic [31:0] adr);
    slave_i[k].cyc = cyc;
    slave_i[k].stb = stb;
    slave_i[k].adr = adr;
    slave_i[k].we  = 1'b1;
    slave_i[k].sel = 4'hF;
    slave_i[k].dat = ~adr;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_accept(input int k, input logic [31:0] adr);
    pend_q.push_back(adr);
    exp_idx_q.push_back(k);
    exp_dat_q.push_back(resp_data(adr));
  endtask

  task automatic drive_ack();
    logic [31:0] a;
    if (pend_q.size() > 0) begin
      a = pend_q.pop_front();
      master_i.ack = 1'b1;
      master_i.dat = resp_data(a);
    end
  endtask

  task automatic check_resp(input string tag);
    int          idx;
    logic [31:0] dat;
    if (exp_idx_q.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s observed=response expected=empty_scoreboard", tag);
    end else begin
      idx = exp_idx_q.pop_front();
      dat = exp_dat_q.pop_front();
      check_output({tag, "_ack"}, 32'(slave_o[idx].ack), 32'd1);
      check_output({tag, "_dat"}, slave_o[idx].dat, dat);
      check_output({tag, "_other_ack"}, 32'(slave_o[1-idx].ack), 32'd0);
    end
  endtask

  initial begin
    int at;
    rst_n_i  = 1'b0;
    slave_i  = '0;
    master_i = '0;

    // Reset holds the bus quiet even with a requester present
    next_cycle();
    next_cycle();
    apply_stimulus(0, 1'b1, 1'b1, 32'h0);
    settle();
    check_output("rst_cyc", 32'(master_o.cyc), 32'd0);
    check_output("rst_stb", 32'(master_o.stb), 32'd0);
    check_output("rst_stall0", 32'(slave_o[0].stall), 32'd1);
    check_output("rst_stall1", 32'(slave_o[1].stall), 32'd1);
    check_output("rst_grant", 32'(grant_o), 32'd0);
    check_output("rst_timeout", 32'(timeout_o), 32'd0);
    next_cycle();
    rst_n_i = 1'b1;
    apply_stimulus(0, 1'b0, 1'b0, 32'h0);

    // Single master, four pipelined writes acked back-to-back
    next_cycle();
    apply_stimulus(0, 1'b1, 1'b0, 32'h100);
    settle();
    check_output("idle_grant", 32'(grant_o), 32'd0);
    check_output("idle_cyc", 32'(master_o.cyc), 32'd0);
    next_cycle();
    settle();
    check_output("n1_grant", 32'(grant_o), 32'd1);
    check_output("n1_cyc", 32'(master_o.cyc), 32'd1);
    apply_stimulus(0, 1'b1, 1'b1, 32'h100);
    expect_accept(0, 32'h100);
    settle();
    check_output("burst_stb0", 32'(master_o.stb), 32'd1);
    check_output("burst_adr0", master_o.adr, 32'h100);
    for (int i = 1; i < 4; i++) begin
      next_cycle();
      apply_stimulus(0, 1'b1, 1'b1, 32'h100 + 32'(4 * i));
      drive_ack();
      expect_accept(0, 32'h100 + 32'(4 * i));
      settle();
      check_resp("burst_resp");
      check_output("burst_stb", 32'(master_o.stb), 32'd1);
      check_output("burst_no_stall", 32'(slave_o[0].stall), 32'd0);
      check_output("burst_adr", master_o.adr, 32'h100 + 32'(4 * i));
    end
    next_cycle();
    apply_stimulus(0, 1'b1, 1'b0, 32'h0);
    drive_ack();
    settle();
    check_resp("burst_last");
    next_cycle();
    apply_stimulus(0, 1'b0, 1'b0, 32'h0);
    settle();
    check_output("drop_cyc", 32'(master_o.cyc), 32'd0);
    next_cycle();
    settle();
    check_output("drop_grant", 32'(grant_o), 32'd0);

    // Simultaneous requests straight out of reset, then hand-over on release
    next_cycle();
    rst_n_i = 1'b0;
    next_cycle();
    rst_n_i = 1'b1;
    apply_stimulus(0, 1'b1, 1'b0, 32'h300);
    apply_stimulus(1, 1'b1, 1'b0, 32'h200);
    next_cycle();
    settle();
    check_output("both_grant0", 32'(grant_o), 32'd1);
    check_output("both_stall1", 32'(slave_o[1].stall), 32'd1);
    next_cycle();
    apply_stimulus(0, 1'b0, 1'b0, 32'h300);
    settle();
    check_output("release_cyc", 32'(master_o.cyc), 32'd0);
    next_cycle();
    apply_stimulus(0, 1'b1, 1'b0, 32'h300);
    settle();
    check_output("handover_idle", 32'(grant_o), 32'd0);
    check_output("handover_stall1", 32'(slave_o[1].stall), 32'd1);
    next_cycle();
    settle();
    check_output("handover_grant1", 32'(grant_o), 32'd2);
    check_output("handover_adr", master_o.adr, 32'h200);
    check_output("nonowner_stall0", 32'(slave_o[0].stall), 32'd1);

    // Outstanding limit of two: third strobe is held until an ack returns
    apply_stimulus(1, 1'b1, 1'b1, 32'h200);
    expect_accept(1, 32'h200);
    settle();
    check_output("lim_stb0", 32'(master_o.stb), 32'd1);
    next_cycle();
    apply_stimulus(1, 1'b1, 1'b1, 32'h204);
    expect_accept(1, 32'h204);
    settle();
    check_output("lim_stb1", 32'(master_o.stb), 32'd1);
    check_output("lim_stall1", 32'(slave_o[1].stall), 32'd0);
    next_cycle();
    apply_stimulus(1, 1'b1, 1'b1, 32'h208);
    settle();
    check_output("lim_full_stb", 32'(master_o.stb), 32'd0);
    check_output("lim_full_stall", 32'(slave_o[1].stall), 32'd1);
    next_cycle();
    drive_ack();
    settle();
    check_resp("lim_ack0");
    check_output("lim_ack_stb", 32'(master_o.stb), 32'd0);
    check_output("lim_no_preempt", 32'(grant_o), 32'd2);
    next_cycle();
    expect_accept(1, 32'h208);
    settle();
    check_output("lim_issue_stb", 32'(master_o.stb), 32'd1);
    check_output("lim_issue_adr", master_o.adr, 32'h208);
    check_output("lim_issue_stall", 32'(slave_o[1].stall), 32'd0);
    next_cycle();
    apply_stimulus(1, 1'b1, 1'b0, 32'h0);
    drive_ack();
    settle();
    check_resp("lim_ack1");
    next_cycle();
    drive_ack();
    settle();
    check_resp("lim_ack2");
    next_cycle();
    apply_stimulus(1, 1'b0, 1'b0, 32'h0);
    apply_stimulus(0, 1'b0, 1'b0, 32'h0);
    next_cycle();
    settle();
    check_output("lim_release", 32'(grant_o), 32'd0);
    check_output("sb_drained", 32'(exp_idx_q.size()), 32'd0);

    // Watchdog: one accepted write that is never answered
    apply_stimulus(0, 1'b1, 1'b0, 32'h400);
    next_cycle();
    settle();
    check_output("wd_grant", 32'(grant_o), 32'd1);
    apply_stimulus(0, 1'b1, 1'b1, 32'h400);
    next_cycle();
    apply_stimulus(0, 1'b1, 1'b0, 32'h400);
    at = 0;
    for (int c = 1; c <= 20; c++) begin
      settle();
      if (timeout_o === 1'b1) begin
        at = c;
        break;
      end
      check_output("wd_cyc_held", 32'(master_o.cyc), 32'd1);
      next_cycle();
    end
    check_output("wd_pulse_cycle", 32'(at), 32'd9);
    check_output("wd_err", 32'(slave_o[0].err), 32'd1);
    check_output("wd_abort_cyc", 32'(master_o.cyc), 32'd0);
    next_cycle();
    settle();
    check_output("wd_pulse_once", 32'(timeout_o), 32'd0);
    check_output("wd_err_once", 32'(slave_o[0].err), 32'd0);
    check_output("wd_abort_stall", 32'(slave_o[0].stall), 32'd1);
    check_output("wd_abort_cyc2", 32'(master_o.cyc), 32'd0);
    next_cycle();
    apply_stimulus(0, 1'b0, 1'b0, 32'h0);
    next_cycle();
    settle();
    check_output("wd_idle_grant", 32'(grant_o), 32'd0);

    // Reset pulse in the middle of a burst
    apply_stimulus(0, 1'b1, 1'b0, 32'h500);
    next_cycle();
    settle();
    check_output("mid_grant", 32'(grant_o), 32'd1);
    apply_stimulus(0, 1'b1, 1'b1, 32'h500);
    next_cycle();
    apply_stimulus(0, 1'b1, 1'b1, 32'h504);
    master_i.ack = 1'b1;
    next_cycle();
    rst_n_i = 1'b0;
    apply_stimulus(0, 1'b1, 1'b1, 32'h508);
    master_i.ack = 1'b1;
    settle();
    check_output("mid_rst_cyc", 32'(master_o.cyc), 32'd0);
    check_output("mid_rst_stall", 32'(slave_o[0].stall), 32'd1);
    check_output("mid_rst_ack", 32'(slave_o[0].ack), 32'd0);
    next_cycle();
    rst_n_i = 1'b1;
    apply_stimulus(0, 1'b1, 1'b1, 32'h600);
    settle();
    check_output("post_rst_grant", 32'(grant_o), 32'd0);
    check_output("post_rst_cyc", 32'(master_o.cyc), 32'd0);
    next_cycle();
    settle();
    check_output("post_rst_regrant", 32'(grant_o), 32'd1);
    check_output("post_rst_stall0", 32'(slave_o[0].stall), 32'd0);
    next_cycle();
    apply_stimulus(0, 1'b1, 1'b1, 32'h604);
    settle();
    check_output("post_rst_stall1", 32'(slave_o[0].stall), 32'd0);
    check_output("post_rst_stb1", 32'(master_o.stb), 32'd1);
    next_cycle();
    apply_stimulus(0, 1'b1, 1'b1, 32'h608);
    settle();
    check_output("post_rst_full", 32'(slave_o[0].stall), 32'd1);
    next_cycle();
    apply_stimulus(0, 1'b0, 1'b0, 32'h0);
    next_cycle();
    settle();
    check_output("end_grant", 32'(grant_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_master_arbiter.md
WB_MASTER_ARBITER -- requirements
Module: wb_master_arbiter

Interface
REQ-001 Parameter g_num_masters, default 2: number of requesting Wishbone masters (2..8).
REQ-002 Parameter g_max_outstanding, default 16: maximum accepted-but-unacknowledged transfers.
REQ-003 Parameter g_timeout, default 1024: cycles without ack/err/rty (outstanding > 0) before abort.
REQ-004 clk_i  in  1  single clock; all logic on its rising edge.
REQ-005 rst_n_i  in  1  reset, synchronous, active-low.
REQ-006 slave_i  in  t_wishbone_master_out[g_num_masters]  requester cyc/stb/we/sel/adr/dat.
REQ-007 slave_o  out  t_wishbone_master_in[g_num_masters]  per-requester ack/err/rty/stall/dat.
REQ-008 master_o  out  t_wishbone_master_out  shared pipelined bus towards interconnect.
REQ-009 master_i  in  t_wishbone_master_in  shared bus response.
REQ-010 grant_o  out  g_num_masters  one-hot current owner, all-zero when idle.
REQ-011 timeout_o  out  1  one-cycle pulse on watchdog abort.

Function
REQ-012 FSM states IDLE, BUSY, ABORT shall be used.
REQ-013 IDLE: when any slave_i(k).cyc=1, grant registered to the first requester searching round-robin from (last owner + 1) mod g_num_masters; go BUSY.
REQ-014 Arbitration latency: requester cyc at edge N -> grant_o and master_o.cyc=1 from edge N+1.
REQ-015 BUSY: master_o = owner's slave_i (combinational passthrough), stb gated per REQ-018; owner's slave_o = master_i.
REQ-016 Non-owners: stall=1, ack=err=rty=0, dat=0, regardless of state.
REQ-017 Outstanding counter (width clog2(g_max_outstanding)+1): +1 on master_o.stb & ~master_i.stall, -1 on ack|err|rty; both in same cycle -> unchanged.
REQ-018 Counter = g_max_outstanding: master_o.stb=0 and owner stall=1 until a response arrives.
REQ-019 Owner drops cyc in BUSY: master_o.cyc=0 same cycle, counter cleared, grant released, state IDLE next edge; late responses ignored.
REQ-020 Grant never changes while owner cyc=1 (no preemption).
REQ-021 Watchdog: counts cycles in BUSY with counter > 0 and no ack/err/rty; reset to 0 on any response or counter = 0.
REQ-022 Watchdog reaching g_timeout: enter ABORT; timeout_o=1 for that one cycle.
REQ-023 ABORT: master_o.cyc=stb=0; owner receives err=1 for exactly the first ABORT cycle, then stall=1 until its cyc=0, then IDLE.
REQ-024 Multiple simultaneous requesters in IDLE: only one granted; others wait with stall=1.

Reset
REQ-025 rst_n_i=0 at an edge: state IDLE, grant_o=0, last owner = g_num_masters-1 (so requester 0 wins first), counters 0, timeout_o=0.
REQ-026 While in reset: master_o.cyc=stb=0, all slave_o stall=1, ack=err=rty=0; reset mid-burst drops cyc immediately without draining.

Structure
REQ-027 t_wishbone_master_in/out and address/data widths come from the shared wishbone package; state enum local to module.
REQ-028 Round-robin priority selector shall be a sub-module, wb_rr_select (request vector + last owner -> one-hot next owner).

Verification
REQ-029 Single master 0: 4 pipelined writes, no stall -> cyc at N+1, 4 acks routed to master 0, grant_o=01, IDLE after cyc drop.
REQ-030 Masters 0 and 1 request same cycle from reset -> master 0 granted; on release with both still requesting -> master 1 granted next.
REQ-031 g_max_outstanding=2, slave withholds acks -> 3rd stb stalled at owner, master_o.stb=0; one ack -> 3rd transfer issued.
REQ-032 g_timeout=8, slave never acks after 1 accepted write -> timeout_o pulse at 8th idle cycle, owner err=1 one cycle, master_o.cyc=0.
REQ-033 Ack and new accepted stb in same cycle with counter=1 -> counter stays 1.
REQ-034 rst_n_i low for one cycle during 4-transfer burst -> master_o.cyc=0 next cycle, grant_o=0, counter 0.
